// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one 16-bit CLA slice per stage, with the operand
// bits of higher slices skewed in and the finished low sum bits carried forward to the output.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SLICES = WIDTH / 16;

  logic             advance;
  logic             in_xfer;
  logic [WIDTH-1:0] b_eff;

  // The whole pipeline moves in lockstep; a full output stage blocks everything behind it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  assign in_xfer  = in_valid && in_ready;
  assign b_eff    = sub ? ~b : b;

  // 4-bit lookahead unit: returns {group P, group G, c3, c2, c1}.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic c0);
    logic c1, c2, c3, gg, gp;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = &p;
    return {gp, gg, c3, c2, c1};
  endfunction

  // Two-level 16-bit CLA: returns {carry out of bit 15, carry into bit 15, sum[15:0]}.
  function automatic logic [17:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                        input logic c0);
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp, gc;
    logic [4:0]  lvl1, top;
    logic        c16;
    g = x & y;
    p = x ^ y;
    for (int i = 0; i < 4; i++) begin
      lvl1  = cla4(g[4*i +: 4], p[4*i +: 4], 1'b0);
      gp[i] = lvl1[4];
      gg[i] = lvl1[3];
    end
    top = cla4(gg, gp, c0);
    gc  = {top[2:0], c0};
    for (int i = 0; i < 4; i++) begin
      lvl1         = cla4(g[4*i +: 4], p[4*i +: 4], gc[i]);
      c[4*i +: 4]  = {lvl1[2:0], gc[i]};
    end
    c16 = top[3] | (top[4] & c0);
    return {c16, c[15], p ^ c};
  endfunction

  for (genvar k = 0; k < SLICES; k++) begin : g_stage
    localparam int unsigned Lo  = 16 * k;
    localparam int unsigned Rem = WIDTH - Lo;

    logic [Rem-1:0]   op_a, op_b;
    logic             c_in, v_in;
    logic [17:0]      res;
    logic [Lo+15:0]   sum_d, sum_q;
    logic             c_q, v_q;

    if (k == 0) begin : g_head
      assign op_a  = a;
      assign op_b  = b_eff;
      assign c_in  = cin;
      assign v_in  = in_xfer;
      assign sum_d = res[15:0];
    end else begin : g_body
      assign op_a  = g_stage[k-1].g_fwd.a_q;
      assign op_b  = g_stage[k-1].g_fwd.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_d = {res[15:0], g_stage[k-1].sum_q};
    end

    assign res = cla16(op_a[15:0], op_b[15:0], c_in);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        c_q   <= res[17];
        sum_q <= sum_d;
      end
    end

    if (k < SLICES - 1) begin : g_fwd
      logic [Rem-17:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= op_a[Rem-1:16];
          b_q <= op_b[Rem-1:16];
        end
      end
    end else begin : g_tail
      logic ovf_q, zero_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= res[17] ^ res[16];
          zero_q <= (sum_d == '0);
        end
      end
      assign out_valid = v_q;
      assign sum       = sum_q;
      assign cout      = c_q;
      assign ovf       = ovf_q;
      assign zero      = zero_q;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench: 32-bit instance checked against a reference model, plus a 64-bit instance
// for the long carry chain and four-stage latency.
module tb_pipelined_cla_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;

  logic        x_in_valid, x_in_ready, x_cin, x_sub, x_out_valid, x_out_ready;
  logic        x_cout, x_ovf, x_zero;
  logic [63:0] x_a, x_b, x_sum;

  pipelined_cla_addsub #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .zero(zero)
  );

  pipelined_cla_addsub #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready), .a(x_a), .b(x_b),
    .cin(x_cin), .sub(x_sub), .out_valid(x_out_valid), .out_ready(x_out_ready), .sum(x_sum),
    .cout(x_cout), .ovf(x_ovf), .zero(x_zero)
  );

  typedef struct {
    logic [34:0] exp;
    int          cyc;
    bit          lat;
  } sb_t;

  sb_t sb_q[$];
  sb_t sb_new;
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;
  int  n_out = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {cout, ovf, zero, sum}; overflow from operand/result signs.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [31:0] yy;
    logic [32:0] t;
    logic        v;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {32'd0, c};
    v  = (x[31] == yy[31]) && (t[31] != x[31]);
    return {t[32], v, (t[31:0] == 32'd0), t[31:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_out", {127'd0, out_valid}, 128'd0);
        end else begin
          check_eq("result", {93'd0, cout, ovf, zero, sum}, {93'd0, sb_q[0].exp});
          if (!out_ready) begin
            for (int i = 0; i < sb_q.size(); i++) sb_q[i].lat = 1'b0;
          end else begin
            if (sb_q[0].lat) check_eq("latency", 128'(cyc - sb_q[0].cyc), 128'd2);
            void'(sb_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_new.exp = model(a, b, cin, sub);
        sb_new.cyc = cyc;
        sb_new.lat = 1'b1;
        sb_q.push_back(sb_new);
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c,
                      input logic s);
    bit acc;
    int n;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    n        = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check_eq("send_timeout", {127'd0, acc}, 128'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
    end
  endtask

  // Single transaction with explicit latency: invalid one cycle after transfer, valid the next.
  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input logic s, input logic [34:0] exp);
    send(x, y, c, s);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_early"}, {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    check_eq(tag, {93'd0, cout, ovf, zero, sum}, {93'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int n_base;
  int lat;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    x_in_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0; x_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_outputs", {93'd0, cout, ovf, zero, sum}, 128'd0);
    check_eq("rst_out_valid64", {127'd0, x_out_valid}, 128'd0);
    rst = 1'b0;

    directed("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0});
    directed("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});
    directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    directed("sub_eq", 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0});

    // Back-to-back random stream.
    n_base = n_out;
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)),
                                     1'($urandom_range(0, 1)));
    idle(4);
    check_eq("stream_count", 128'(n_out - n_base), 128'd8);

    // Backpressure with the pipeline full; operands offered while stalled must be ignored.
    n_base    = n_out;
    out_ready = 1'b0;
    send(32'h1111_0000, 32'h0000_FFFF, 1'b1, 1'b0);
    send(32'h0001_0000, 32'h0000_0001, 1'b1, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      check_eq("stall_in_ready", {127'd0, in_ready}, 128'd0);
      check_eq("stall_out_valid", {127'd0, out_valid}, 128'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    idle(4);
    check_eq("stall_count", 128'(n_out - n_base), 128'd4);

    // Reset with two transactions in flight.
    n_base = n_out;
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    send(32'h0BAD_F00D, 32'h0000_0001, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("flush_out_valid", {127'd0, out_valid}, 128'd0);
    idle(5);
    check_eq("flush_count", 128'(n_out - n_base), 128'd0);
    directed("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h100});

    // 64-bit carry chain through three slice boundaries.
    x_in_valid = 1'b1;
    x_a        = 64'h0000_FFFF_FFFF_FFFF;
    x_b        = 64'h1;
    @(negedge clk);
    check_eq("w64_in_ready", {127'd0, x_in_ready}, 128'd1);
    @(posedge clk);
    #1;
    x_in_valid = 1'b0;
    lat        = 1;
    @(negedge clk);
    while (!x_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("w64_latency", 128'(lat), 128'd4);
    check_eq("w64_result", {61'd0, x_cout, x_ovf, x_zero, x_sum},
             {61'd0, 1'b0, 1'b0, 1'b0, 64'h0001_0000_0000_0000});

    idle(3);
    check_eq("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
